serial_bus_arbiter: RTL and testbench

Parametrised shared serial bus for N_NODES transmitting nodes. It arbitrates round-robin among requesting nodes and latches the winner's destination address and payload. It serialises one framed packet onto a single-wire bus and generates the CRC in hardware instead of taking it as a node input. It replaces the fixed 16-node, 64-bit, priority-by-mode bus with a generic, fair, CRC-generating bus master.

---
 rtl/serial_bus_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_serial_bus_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbitrated single-wire serial bus master.
// Frames: start bit, source id, destination, payload, then a serially generated CRC.
module serial_bus_arbiter #(
  parameter int unsigned N_NODES = 16,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned SRC_W = 4,
  parameter int unsigned CRC_W = 4,
  parameter logic [CRC_W-1:0] CRC_POLY = 4'h3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [N_NODES-1:0]         req,
  input  logic [N_NODES*DATA_W-1:0]  data_in,
  input  logic [N_NODES*ADDR_W-1:0]  addr_in,
  output logic [N_NODES-1:0]         grant,
  output logic                       bus_show,
  output logic                       bus_busy,
  output logic                       frame_done
);

  localparam int unsigned MAX_AD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned MAX_SC = (SRC_W > CRC_W) ? SRC_W : CRC_W;
  localparam int unsigned MAX_W  = (MAX_AD > MAX_SC) ? MAX_AD : MAX_SC;
  localparam int unsigned CNT_W  = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [2:0] {IDLE, START, SRC, DST, DATA, CRC, GAP} state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [SRC_W-1:0]    ptr, ptr_nx;
  logic [SRC_W-1:0]    src_id, src_id_nx;
  logic [SRC_W-1:0]    src_sh, src_sh_nx;
  logic [ADDR_W-1:0]   addr_sh, addr_sh_nx;
  logic [DATA_W-1:0]   data_sh, data_sh_nx;
  logic [CRC_W-1:0]    crc, crc_nx;

  logic [2*N_NODES-1:0] req_dbl;
  logic [N_NODES-1:0]   req_rot;
  logic                 found, hit;
  int unsigned          off, win_sum;
  logic [SRC_W-1:0]     win;
  logic [DATA_W-1:0]    data_pick;
  logic [ADDR_W-1:0]    addr_pick;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = b ^ c[CRC_W-1];
    return (c << 1) ^ (fb ? CRC_POLY : '0);
  endfunction

  // Rotate requests so the pointer sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req};
    req_rot = N_NODES'(req_dbl >> ptr);
    found   = |req_rot;
    hit     = 1'b0;
    off     = 0;
    for (int unsigned i = 0; i < N_NODES; i++) begin
      if (req_rot[i] && !hit) begin
        hit = 1'b1;
        off = i;
      end
    end
    win_sum = int'(ptr) + off;
    if (win_sum >= N_NODES) win_sum = win_sum - N_NODES;
    win = SRC_W'(win_sum);
  end

  always_comb begin
    data_pick = '0;
    addr_pick = '0;
    for (int unsigned i = 0; i < N_NODES; i++) begin
      if (win == SRC_W'(i)) begin
        data_pick = data_in[i*DATA_W +: DATA_W];
        addr_pick = addr_in[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= '0;
      src_id  <= '0;
      src_sh  <= '0;
      addr_sh <= '0;
      data_sh <= '0;
      crc     <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      ptr     <= ptr_nx;
      src_id  <= src_id_nx;
      src_sh  <= src_sh_nx;
      addr_sh <= addr_sh_nx;
      data_sh <= data_sh_nx;
      crc     <= crc_nx;
    end
  end

  // Each field shifts its MSB onto the line; the CRC absorbs the bit being shown.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    ptr_nx     = ptr;
    src_id_nx  = src_id;
    src_sh_nx  = src_sh;
    addr_sh_nx = addr_sh;
    data_sh_nx = data_sh;
    crc_nx     = crc;
    case (state)
      IDLE, GAP: begin
        if (found) begin
          state_nx   = START;
          src_id_nx  = win;
          src_sh_nx  = win;
          addr_sh_nx = addr_pick;
          data_sh_nx = data_pick;
          crc_nx     = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        state_nx = SRC;
        cnt_nx   = CNT_W'(SRC_W - 1);
      end
      SRC: begin
        crc_nx    = crc_step(crc, src_sh[SRC_W-1]);
        src_sh_nx = src_sh << 1;
        if (cnt == '0) begin
          state_nx = DST;
          cnt_nx   = CNT_W'(ADDR_W - 1);
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DST: begin
        crc_nx     = crc_step(crc, addr_sh[ADDR_W-1]);
        addr_sh_nx = addr_sh << 1;
        if (cnt == '0) begin
          state_nx = DATA;
          cnt_nx   = CNT_W'(DATA_W - 1);
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DATA: begin
        crc_nx     = crc_step(crc, data_sh[DATA_W-1]);
        data_sh_nx = data_sh << 1;
        if (cnt == '0) begin
          state_nx = CRC;
          cnt_nx   = CNT_W'(CRC_W - 1);
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      CRC: begin
        crc_nx = crc << 1;
        if (cnt == '0) begin
          state_nx = GAP;
          ptr_nx   = (src_id == SRC_W'(N_NODES - 1)) ? '0 : src_id + 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus_show = 1'b0;
    case (state)
      START:   bus_show = 1'b1;
      SRC:     bus_show = src_sh[SRC_W-1];
      DST:     bus_show = addr_sh[ADDR_W-1];
      DATA:    bus_show = data_sh[DATA_W-1];
      CRC:     bus_show = crc[CRC_W-1];
      default: bus_show = 1'b0;
    endcase
  end

  assign bus_busy   = (state != IDLE) && (state != GAP);
  assign frame_done = (state == GAP);

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < N_NODES; i++) begin
      grant[i] = bus_busy && (src_id == SRC_W'(i));
    end
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter at default parameters.
module tb_serial_bus_arbiter;

  localparam int L = 77;

  logic           clock;
  logic           reset_n;
  logic [15:0]    req;
  logic [1023:0]  data_in;
  logic [63:0]    addr_in;
  logic [15:0]    grant;
  logic           bus_show;
  logic           bus_busy;
  logic           frame_done;

  int checks = 0;
  int errors = 0;

  serial_bus_arbiter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .data_in    (data_in),
    .addr_in    (addr_in),
    .grant      (grant),
    .bus_show   (bus_show),
    .bus_busy   (bus_busy),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC by polynomial long division of msg*x^4 by x^4+x+1.
  function automatic logic [3:0] crc_ref(input logic [71:0] msg);
    logic [75:0] m;
    m = {msg, 4'b0000};
    for (int i = 75; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  function automatic logic [L-1:0] frame_of(input logic [3:0] s, input logic [3:0] a, input logic [63:0] d);
    return {1'b1, s, a, d, crc_ref({s, a, d})};
  endfunction

  task automatic capture(input int change_at, output logic [L-1:0] frm, output logic [15:0] gnt,
                         output logic steady, output int waited);
    waited = 0;
    steady = 1'b1;
    frm    = '0;
    @(negedge clock);
    while (!bus_busy && waited < 300) begin
      waited++;
      @(negedge clock);
    end
    gnt = grant;
    for (int k = 0; k < L; k++) begin
      if (k > 0) @(negedge clock);
      frm[L-1-k] = bus_show;
      if (grant !== gnt || bus_busy !== 1'b1 || frame_done !== 1'b0) steady = 1'b0;
      if (k == change_at) begin
        req            = '0;
        data_in[63:0]  = '1;
        addr_in[3:0]   = 4'h5;
      end
    end
  endtask

  task automatic gap_check(input string tag);
    @(negedge clock);
    chk({tag, "_done"}, frame_done, 1'b1);
    chk({tag, "_busy"}, bus_busy, 1'b0);
    chk({tag, "_grant"}, grant, 16'h0000);
    chk({tag, "_bus"}, bus_show, 1'b0);
  endtask

  logic [L-1:0] frm;
  logic [15:0]  gnt;
  logic         steady;
  int           waited;
  int           seen;

  initial begin
    reset_n = 1'b0;
    req     = '0;
    data_in = '0;
    addr_in = '0;
    #12;
    chk("rst_bus", bus_show, 1'b0);
    chk("rst_busy", bus_busy, 1'b0);
    chk("rst_grant", grant, 16'h0000);
    chk("rst_done", frame_done, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // Idle line
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (bus_show !== 1'b0 || bus_busy !== 1'b0 || frame_done !== 1'b0) seen++;
    end
    chk("idle_quiet", seen, 0);

    // Single request with hand-computed frame
    addr_in[3:0]  = 4'h1;
    data_in[63:0] = 64'h1;
    req           = 16'h0001;
    capture(-1, frm, gnt, steady, waited);
    req = '0;
    chk("t1_latency", waited, 0);
    chk("t1_grant", gnt, 16'h0001);
    chk("t1_steady", steady, 1'b1);
    chk("t1_frame", frm, {1'b1, 4'h0, 4'h1, 64'h1, 4'h6});
    gap_check("t1_gap");
    @(negedge clock);
    chk("t1_pulse_len", frame_done, 1'b0);

    // Reset pulse brings the pointer back to node 0
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // Contention between nodes 0 and 2
    addr_in[3:0]             = 4'h3;
    data_in[63:0]            = 64'hDEAD_BEEF_0000_0001;
    addr_in[2*4 +: 4]        = 4'hC;
    data_in[2*64 +: 64]      = 64'h8000_0000_0000_00A5;
    req                      = 16'h0005;
    capture(-1, frm, gnt, steady, waited);
    chk("c1_grant", gnt, 16'h0001);
    chk("c1_steady", steady, 1'b1);
    chk("c1_frame", frm, frame_of(4'h0, 4'h3, 64'hDEAD_BEEF_0000_0001));
    gap_check("c1_gap");
    capture(-1, frm, gnt, steady, waited);
    chk("c2_one_idle_bit", waited, 0);
    chk("c2_grant", gnt, 16'h0004);
    chk("c2_frame", frm, frame_of(4'h2, 4'hC, 64'h8000_0000_0000_00A5));
    gap_check("c2_gap");
    capture(-1, frm, gnt, steady, waited);
    req = '0;
    chk("c3_waited", waited, 0);
    chk("c3_grant", gnt, 16'h0001);
    chk("c3_frame", frm, frame_of(4'h0, 4'h3, 64'hDEAD_BEEF_0000_0001));
    gap_check("c3_gap");
    @(negedge clock);
    chk("c3_no_restart", bus_busy, 1'b0);

    // Round-robin wrap: node 14 first, then 15 ahead of 0
    addr_in[14*4 +: 4]   = 4'hE;
    data_in[14*64 +: 64] = 64'h0F0F_0F0F_0F0F_0F0F;
    addr_in[15*4 +: 4]   = 4'h7;
    data_in[15*64 +: 64] = 64'hFFFF_0000_1234_5678;
    req                  = 16'h4000;
    capture(-1, frm, gnt, steady, waited);
    req = 16'h8001;
    chk("w1_grant", gnt, 16'h4000);
    chk("w1_frame", frm, frame_of(4'hE, 4'hE, 64'h0F0F_0F0F_0F0F_0F0F));
    gap_check("w1_gap");
    capture(-1, frm, gnt, steady, waited);
    req = 16'h0001;
    chk("w2_grant", gnt, 16'h8000);
    chk("w2_frame", frm, frame_of(4'hF, 4'h7, 64'hFFFF_0000_1234_5678));
    gap_check("w2_gap");
    capture(-1, frm, gnt, steady, waited);
    req = '0;
    chk("w3_waited", waited, 0);
    chk("w3_grant", gnt, 16'h0001);
    chk("w3_frame", frm, frame_of(4'h0, 4'h3, 64'hDEAD_BEEF_0000_0001));
    gap_check("w3_gap");

    // Mid-frame changes to req, data and address are ignored
    @(negedge clock);
    addr_in[3:0]  = 4'hA;
    data_in[63:0] = 64'h0123_4567_89AB_CDEF;
    req           = 16'h0001;
    capture(20, frm, gnt, steady, waited);
    chk("m_grant", gnt, 16'h0001);
    chk("m_steady", steady, 1'b1);
    chk("m_frame", frm, frame_of(4'h0, 4'hA, 64'h0123_4567_89AB_CDEF));
    gap_check("m_gap");
    @(negedge clock);
    chk("m_no_restart", bus_busy, 1'b0);

    // Asynchronous reset mid-frame
    req  = 16'h0001;
    seen = 0;
    @(negedge clock);
    while (!bus_busy && seen < 300) begin
      seen++;
      @(negedge clock);
    end
    repeat (30) @(negedge clock);
    chk("ar_pre_bus", bus_show, 1'b1);
    chk("ar_pre_grant", grant, 16'h0001);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_bus", bus_show, 1'b0);
    chk("ar_busy", bus_busy, 1'b0);
    chk("ar_grant", grant, 16'h0000);
    chk("ar_done", frame_done, 1'b0);
    req = 16'h0003;
    @(negedge clock);
    reset_n = 1'b1;
    capture(-1, frm, gnt, steady, waited);
    req = '0;
    chk("ar_restart_waited", waited, 0);
    chk("ar_restart_grant", gnt, 16'h0001);
    chk("ar_restart_frame", frm, frame_of(4'h0, 4'h5, 64'hFFFF_FFFF_FFFF_FFFF));
    gap_check("ar_gap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
